// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two W-bit operands one 4-bit slice per cycle.
// Build option: CSKIP_SUB_EN adds a 'sub' port for A - B.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   a, b, cin         operands, sampled on accept (IDLE & in_valid)
//   in_valid/in_ready input handshake (ready only in IDLE)
//   s, c              sum and carry out, valid while out_valid
//   out_valid/out_ready output handshake (valid only in DONE)
//   sub               (CSKIP_SUB_EN only) subtract A - B
//   busy              high in RUN and DONE
module nibble_serial_adder #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4*NIB-1:0] s,
    output logic             c,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSKIP_SUB_EN
    input  logic             sub,
`endif
    output logic             busy
);

    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        nstate;
    logic [KW-1:0] k;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          cy;

    logic [W-1:0]  bsel;
    logic          cysel;

    logic [3:0]    an;
    logic [3:0]    bn;
    logic [3:0]    p;
    logic [3:0]    g;
    logic [3:0]    sum_n;
    logic          rc;
    logic          cout_n;
    logic          last;

    // Operand conditioning at accept. Subtraction is A + ~B + 1,
    // so the final carry doubles as the no-borrow flag.
`ifdef CSKIP_SUB_EN
    always_comb begin
        bsel  = sub ? ~b : b;
        cysel = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        bsel  = b;
        cysel = cin;
    end
`endif

    // One 4-bit slice: ripple chain for the sum, with a skip path
    // that forwards the slice carry-in when every bit propagates.
    always_comb begin
        an     = opa[4*k +: 4];
        bn     = opb[4*k +: 4];
        p      = an ^ bn;
        g      = an & bn;
        rc     = cy;
        sum_n  = '0;
        for (int i = 0; i < 4; i++) begin
            sum_n[i] = p[i] ^ rc;
            rc       = g[i] | (p[i] & rc);
        end
        cout_n = (&p) ? cy : rc;
    end

    assign last = (k == KLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (in_valid) nstate = RUN;
            RUN:  if (last) nstate = DONE;
            DONE: if (out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= '0;
            opa <= '0;
            opb <= '0;
            cy  <= 1'b0;
            s   <= '0;
            c   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa <= a;
                        opb <= bsel;
                        cy  <= cysel;
                        k   <= '0;
                    end
                end
                RUN: begin
                    s[4*k +: 4] <= sum_n;
                    cy          <= cout_n;
                    k           <= k + KW'(1);
                    if (last) c <= cout_n;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIB=4, add-only build).
// Reference result is plain W+1-bit arithmetic on the operands.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic         c;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int total;
    int passed;

    nibble_serial_adder #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Full transaction: accept, RUN latency, DONE hold with
    // backpressure for 'hold' cycles, then release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int hold);
        logic [W:0] ref_sum;
        ref_sum = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        @(negedge clk);
        a = ta; b = tb; cin = tc;
        in_valid = 1'b1; out_ready = 1'b0;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            out_ready = 1'($urandom);
            chk("run_flags", {29'd0, busy, in_ready, out_valid}, 32'b100);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_valid", {29'd0, busy, in_ready, out_valid}, 32'b101);
        chk("sum", {16'd0, s}, {16'd0, ref_sum[W-1:0]});
        chk("carry", {31'd0, c}, {31'd0, ref_sum[W]});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold", {14'd0, out_valid, in_ready, c, s},
                {14'd0, 1'b1, 1'b0, ref_sum[W], ref_sum[W-1:0]});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release", {29'd0, busy, in_ready, out_valid}, 32'b010);
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_state", {12'd0, busy, in_ready, out_valid, c, s},
            {12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0);
        run_op(16'hF0F0, 16'h0F0F, 1'b1, 1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 5);

        for (int r = 0; r < 20; r++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        // Reset in mid-RUN discards the operation.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run", {12'd0, busy, in_ready, out_valid, c, s},
            {12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * NIB; i++) begin
            @(negedge clk);
            chk("no_result", {30'd0, out_valid, busy}, 32'd0);
        end

        // Reset held in DONE also discards.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (NIB) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_done", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_done", {12'd0, busy, in_ready, out_valid, c, s},
            {12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'hFFFF, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
